// File: rtl/screen_pkg.sv
// screen_pkg: framebuffer geometry, pixel width and clear-FSM state type
//   shared by screen_clear_engine and screen_memory_arbiter
package screen_pkg;
   localparam int FB_W = 128;
   localparam int FB_H = 128;
   localparam int COORD_W = 7;
   localparam int PIXEL_W = 16;
   localparam int FB_PIXELS = 16384;
   localparam int ADDR_W = 2 * COORD_W;
   typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/screen_clear_engine.sv
// screen_clear_engine: fills the framebuffer with a latched colour, one pixel per grant
//   clk, rst        clock, synchronous active-high reset
//   clear_start     start a fill (ignored while busy)
//   clear_color     colour latched on start
//   grant           the arbiter accepted this cycle's clear write
//   busy, done      fill in progress; one-cycle pulse after the last pixel
//   addr_x, addr_y  current pixel, x fastest
//   color           latched fill colour
module screen_clear_engine
   import screen_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear_start,
   input  logic [PIXEL_W-1:0] clear_color,
   input  logic               grant,
   output logic               busy,
   output logic               done,
   output logic [COORD_W-1:0] addr_x,
   output logic [COORD_W-1:0] addr_y,
   output logic [PIXEL_W-1:0] color
);
   state_t state, state_n;
   logic [ADDR_W-1:0] addr;
   logic last;
   assign busy = state == CLEAR;
   assign addr_x = addr[COORD_W-1:0];
   assign addr_y = addr[ADDR_W-1:COORD_W];
   assign last = busy && grant && addr == ADDR_W'(FB_PIXELS - 1);
   always_comb begin
      state_n = state;
      state_n = busy ? (last ? IDLE : CLEAR) : (clear_start ? CLEAR : IDLE);
   end
   // the counter wraps to 0 after the last pixel, so it is ready for the next fill
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         addr  <= '0;
         color <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         done  <= last;
         if (!busy && clear_start) begin
            addr  <= '0;
            color <= clear_color;
         end else if (busy && grant) begin
            addr <= addr + 1'b1;
         end
      end
   end
endmodule

// File: rtl/screen_memory_arbiter.sv
// screen_memory_arbiter: shares one framebuffer port between refresh reads, draw writes and clear
//   rd_*      refresh read request/ack and one-cycle-later response
//   wr_*      draw write request/ack (draw port is parked while clearing)
//   clear_*   fill command, busy flag, completion pulse
//   mem_*     framebuffer read/write port; mem_data_out arrives one cycle after mem_rd_en
module screen_memory_arbiter
   import screen_pkg::*;
#(
   parameter int MAX_RD_BURST = 4
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_req,
   input  logic [COORD_W-1:0] rd_x,
   input  logic [COORD_W-1:0] rd_y,
   output logic               rd_ack,
   output logic               rd_valid,
   output logic [PIXEL_W-1:0] rd_data,
   input  logic               wr_req,
   input  logic [COORD_W-1:0] wr_x,
   input  logic [COORD_W-1:0] wr_y,
   input  logic [PIXEL_W-1:0] wr_data,
   output logic               wr_ack,
   input  logic               clear_start,
   input  logic [PIXEL_W-1:0] clear_color,
   output logic               clear_busy,
   output logic               clear_done,
   output logic               mem_rd_en,
   output logic [COORD_W-1:0] mem_rd_addr_x,
   output logic [COORD_W-1:0] mem_rd_addr_y,
   output logic               mem_wr_en,
   output logic [COORD_W-1:0] mem_wr_addr_x,
   output logic [COORD_W-1:0] mem_wr_addr_y,
   output logic [PIXEL_W-1:0] mem_data_in,
   input  logic [PIXEL_W-1:0] mem_data_out,
   input  logic               mem_valid_out
);
   localparam int SW = $clog2(MAX_RD_BURST + 1);
   logic [SW-1:0] rd_streak;
   logic rd_inflight, wr_pend, rd_grant, wr_grant;
   logic [COORD_W-1:0] clr_x, clr_y;
   logic [PIXEL_W-1:0] clr_color;
   logic unused;
   // response timing is fixed at one cycle, so the memory's valid flag carries no extra information
   assign unused = mem_valid_out;
   screen_clear_engine u_clear (
      .clk        (clk),
      .rst        (rst),
      .clear_start(clear_start),
      .clear_color(clear_color),
      .grant      (wr_grant && clear_busy),
      .busy       (clear_busy),
      .done       (clear_done),
      .addr_x     (clr_x),
      .addr_y     (clr_y),
      .color      (clr_color)
   );
   // reads win until MAX_RD_BURST of them have starved a pending write
   always_comb begin
      wr_pend       = clear_busy || wr_req;
      rd_grant      = rd_req && !(wr_pend && rd_streak == SW'(MAX_RD_BURST));
      wr_grant      = wr_pend && !rd_grant;
      rd_ack        = rd_grant;
      wr_ack        = wr_grant && !clear_busy;
      mem_rd_en     = rd_grant;
      mem_rd_addr_x = rd_grant ? rd_x : '0;
      mem_rd_addr_y = rd_grant ? rd_y : '0;
      mem_wr_en     = wr_grant;
      mem_wr_addr_x = !wr_grant ? '0 : clear_busy ? clr_x : wr_x;
      mem_wr_addr_y = !wr_grant ? '0 : clear_busy ? clr_y : wr_y;
      mem_data_in   = !wr_grant ? '0 : clear_busy ? clr_color : wr_data;
      rd_valid      = rd_inflight;
      rd_data       = rd_inflight ? mem_data_out : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_streak   <= '0;
         rd_inflight <= 1'b0;
      end else begin
         rd_inflight <= rd_grant;
         rd_streak   <= (wr_grant || !wr_pend) ? '0 : rd_streak + SW'(rd_grant);
      end
   end
endmodule

// File: tb/tb_screen_memory_arbiter.sv
// tb_screen_memory_arbiter: directed stimulus with a per-cycle behavioural model and literal checks
module tb_screen_memory_arbiter;
   import screen_pkg::*;
   localparam int MRB = 4;
   logic clk = 1'b0;
   logic rst, fb_init;
   logic rd_req, wr_req, clear_start;
   logic [6:0] rd_x, rd_y, wr_x, wr_y;
   logic [15:0] wr_data, clear_color;
   logic rd_ack, rd_valid, wr_ack, clear_busy, clear_done, mem_rd_en, mem_wr_en;
   logic [15:0] rd_data, mem_data_in, mem_data_out;
   logic [6:0] mem_rd_addr_x, mem_rd_addr_y, mem_wr_addr_x, mem_wr_addr_y;
   logic mem_valid_out;
   logic [15:0] fb [FB_PIXELS];
   logic [15:0] gold [FB_PIXELS];
   int checks = 0, failures = 0, done_cnt = 0;

   always #5 clk = ~clk;

   screen_memory_arbiter #(.MAX_RD_BURST(MRB)) dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_ack(rd_ack),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ack(wr_ack),
      .clear_start(clear_start), .clear_color(clear_color),
      .clear_busy(clear_busy), .clear_done(clear_done),
      .mem_rd_en(mem_rd_en), .mem_rd_addr_x(mem_rd_addr_x), .mem_rd_addr_y(mem_rd_addr_y),
      .mem_wr_en(mem_wr_en), .mem_wr_addr_x(mem_wr_addr_x), .mem_wr_addr_y(mem_wr_addr_y),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_valid_out(mem_valid_out)
   );

   // framebuffer SPRAM: synchronous read, one cycle latency
   always @(posedge clk) begin
      if (fb_init) begin
         for (int i = 0; i < FB_PIXELS; i++) fb[i] <= 16'(i * 3 + 1);
         mem_valid_out <= 1'b0;
         mem_data_out  <= 16'h0;
      end else begin
         mem_valid_out <= mem_rd_en;
         if (mem_rd_en) mem_data_out <= fb[{mem_rd_addr_y, mem_rd_addr_x}];
         if (mem_wr_en) fb[{mem_wr_addr_y, mem_wr_addr_x}] <= mem_data_in;
      end
   end

   // behavioural model: pixels cleared so far, reads since the last write, pending response
   initial begin
      bit mbusy, mdone, mvpend, pend, e_rd, e_wr;
      int mpix, mreads, waddr;
      logic [15:0] mcolor, mvdata, wdat;
      logic [13:0] raddr;
      logic [66:0] exp_v, got_v;
      mbusy = 0; mdone = 0; mvpend = 0; mpix = 0; mreads = 0; mcolor = 0; mvdata = 0;
      forever begin
         @(negedge clk);
         if (fb_init) begin
            for (int i = 0; i < FB_PIXELS; i++) gold[i] = 16'(i * 3 + 1);
            continue;
         end
         pend  = mbusy || wr_req;
         e_rd  = rd_req && !(pend && mreads >= MRB);
         e_wr  = pend && !e_rd;
         waddr = mbusy ? mpix : int'({wr_y, wr_x});
         wdat  = mbusy ? mcolor : wr_data;
         raddr = {rd_y, rd_x};
         exp_v = {e_rd, e_wr && !mbusy, e_rd, e_wr, mvpend, mvpend ? mvdata : 16'h0,
                  mbusy, mdone, e_rd ? raddr : 14'h0, e_wr ? 14'(waddr) : 14'h0,
                  e_wr ? wdat : 16'h0};
         got_v = {rd_ack, wr_ack, mem_rd_en, mem_wr_en, rd_valid, rd_data, clear_busy,
                  clear_done, mem_rd_addr_y, mem_rd_addr_x, mem_wr_addr_y, mem_wr_addr_x,
                  mem_data_in};
         checks++;
         if (got_v !== exp_v) begin
            failures++;
            $display("FAIL cycle t=%0t got=%h expected=%h", $time, got_v, exp_v);
         end
         checks++;
         if (mem_rd_en && mem_wr_en) begin
            failures++;
            $display("FAIL both_en t=%0t got=11 expected=not both", $time);
         end
         if (clear_done) done_cnt++;
         if (e_wr) gold[waddr] = wdat;
         mvdata = gold[raddr];
         if (rst) begin
            mbusy = 0; mdone = 0; mvpend = 0; mpix = 0; mreads = 0; mcolor = 0;
         end else begin
            mvpend = e_rd;
            mreads = (pend && !e_wr) ? mreads + 1 : 0;
            mdone = 0;
            if (mbusy) begin
               if (e_wr) begin
                  mpix++;
                  if (mpix == FB_PIXELS) begin
                     mbusy = 0; mpix = 0; mdone = 1;
                  end
               end
            end else if (clear_start) begin
               mbusy = 1; mpix = 0; mcolor = clear_color;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string n, input logic [31:0] g, input logic [31:0] e);
      checks++;
      if (g !== e) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", n, g, e);
      end
   endtask

   task automatic rd(input logic [6:0] x, input logic [6:0] y, output logic [15:0] d);
      int n;
      n = 0;
      rd_req = 1; rd_x = x; rd_y = y; #1;
      while (!rd_ack && n < 50) begin
         step(); #1; n++;
      end
      if (!rd_ack) lit("rd_timeout", 0, 1);
      step();
      rd_req = 0; #1;
      d = rd_data;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      logic [9:0] pat;
      int cnt, first_wr, d0, wcnt, wack;
      rst = 1; fb_init = 1;
      rd_req = 0; wr_req = 0; clear_start = 0;
      rd_x = 0; rd_y = 0; wr_x = 0; wr_y = 0; wr_data = 0; clear_color = 0;
      step(); step();
      fb_init = 0; rst = 0; #1;
      lit("reset_outs", {23'h0, rd_ack, wr_ack, rd_valid, clear_busy, clear_done, mem_rd_en,
          mem_wr_en, |rd_data, |{mem_rd_addr_x, mem_rd_addr_y, mem_wr_addr_x, mem_wr_addr_y,
          mem_data_in}}, 0);
      // write then read back (5,70)
      step();
      wr_req = 1; wr_x = 5; wr_y = 70; wr_data = 16'hF800; #1;
      lit("wr_ack_5_70", 32'(wr_ack), 1);
      step();
      wr_req = 0; rd_req = 1; rd_x = 5; rd_y = 70; #1;
      lit("rd_ack_5_70", 32'(rd_ack), 1);
      step();
      rd_req = 0; #1;
      lit("rd_valid_n1", 32'(rd_valid), 1);
      lit("rd_data_n1", 32'(rd_data), 32'hF800);
      // read granted during reset must not respond
      step();
      rst = 1; rd_req = 1;
      step();
      rst = 0; rd_req = 0; #1;
      lit("rd_valid_after_rst", 32'(rd_valid), 0);
      // contention pattern R,R,R,R,W
      step();
      rd_req = 1; rd_x = 1; rd_y = 1; wr_req = 1; wr_x = 2; wr_y = 2; wr_data = 16'h0BAD;
      first_wr = -1;
      for (int i = 0; i < 10; i++) begin
         #1;
         pat[9-i] = rd_ack;
         if (wr_ack && first_wr < 0) first_wr = i + 1;
         step();
      end
      rd_req = 0; wr_req = 0;
      lit("burst_pattern", 32'(pat), 32'b1111011110);
      lit("first_wr_ack", 32'(first_wr), 5);
      // full clear, no reads
      step();
      d0 = done_cnt;
      clear_start = 1; clear_color = 16'h001F;
      step();
      clear_start = 0;
      cnt = 0;
      while (clear_busy && cnt < 20000) begin
         cnt++; step();
      end
      lit("clear_cycles", 32'(cnt), 16384);
      #1;
      lit("clear_done_pulse", 32'(clear_done), 1);
      step();
      lit("done_count_1", 32'(done_cnt - d0), 1);
      rd(0, 0, d);
      lit("clr_0_0", 32'(d), 32'h001F);
      step();
      rd(127, 127, d);
      lit("clr_127_127", 32'(d), 32'h001F);
      // reset during clear after pixel 99
      step();
      d0 = done_cnt;
      clear_start = 1; clear_color = 16'h07E0;
      step();
      clear_start = 0;
      repeat (99) step();
      rst = 1;
      step();
      rst = 0; #1;
      lit("abort_busy", 32'(clear_busy), 0);
      lit("abort_rd_valid", 32'(rd_valid), 0);
      step(); step();
      lit("abort_no_done", 32'(done_cnt - d0), 0);
      lit("pix99", 32'(fb[99]), 32'h07E0);
      lit("pix100", 32'(fb[100]), 32'h001F);
      // draw write with clear_start, reads during clear, restart attempt mid-clear
      step();
      d0 = done_cnt; wack = 0; wcnt = 0;
      wr_req = 1; wr_x = 3; wr_y = 3; wr_data = 16'hABCD;
      clear_start = 1; clear_color = 16'h1234; #1;
      lit("draw_before_clear", 32'(wr_ack), 1);
      step();
      clear_start = 0; rd_req = 1; rd_x = 0; rd_y = 0;
      repeat (50) begin
         #1;
         wcnt += int'(mem_wr_en);
         wack += int'(wr_ack);
         step();
      end
      rd_req = 0;
      lit("writes_in_50", 32'(wcnt), 10);
      repeat (1000) begin
         #1; wack += int'(wr_ack); step();
      end
      clear_start = 1; clear_color = 16'hFFFF;
      step();
      clear_start = 0;
      cnt = 0;
      while (clear_busy && cnt < 20000) begin
         #1; wack += int'(wr_ack); cnt++; step();
      end
      #1;
      lit("clear2_done", 32'(clear_done), 1);
      lit("draw_after_clear", 32'(wr_ack), 1);
      lit("no_wr_ack_in_clear", 32'(wack), 0);
      step();
      wr_req = 0;
      step();
      lit("done_count_2", 32'(done_cnt - d0), 1);
      lit("color_kept", 32'(fb[16383]), 32'h1234);
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
